// File: rtl/weight_load_sequencer.sv
// Streams one layer's weight image onto the shared PE weight write bus, assigning
// consecutive addresses from BASE_ADDR and flagging load_ok once every word has landed.
module weight_load_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'd23,
    parameter int unsigned NUM_WORDS = 226,
    parameter int unsigned WR_GAP    = 0,
    parameter int unsigned DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] weight_wr_data,
    output logic [31:0]       weight_wr_addr,
    output logic              weight_wr_en,
    output logic              busy,
    output logic              done,
    output logic              load_ok,
    output logic [31:0]       word_cnt
);

    localparam int unsigned       GAP_W    = (WR_GAP < 2) ? 1 : $clog2(WR_GAP);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((WR_GAP == 0) ? 0 : WR_GAP - 1);
    localparam logic [31:0]       LAST_IDX = 32'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;
    logic [31:0]        r_word_cnt;
    logic               r_load_ok;
    logic               r_done;

    logic [DATA_W-1:0]  r_wr_data_p1;
    logic [31:0]        r_wr_addr_p1;
    logic               r_wr_en_p1;

    logic               w_s_ready;
    logic               w_hs;
    logic               w_start_acc;
    logic               w_done_nxt;
    logic               w_load_ok_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        w_s_ready     = 1'b0;
        w_hs          = 1'b0;
        w_start_acc   = 1'b0;
        w_done_nxt    = 1'b0;
        w_load_ok_nxt = r_load_ok;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt   = S_LOAD;
                    w_start_acc   = 1'b1;
                    w_load_ok_nxt = 1'b0;
                end
            end
            S_LOAD: begin
                w_s_ready = !abort;
                w_hs      = s_valid && !abort;
                if (w_hs) begin
                    if (r_word_cnt == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else if (WR_GAP > 0) begin
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = '0;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt   = S_IDLE;
                w_done_nxt    = 1'b1;
                w_load_ok_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // abort overrides every transition, including the DONE -> IDLE completion
        if (abort) begin
            w_state_nxt   = S_IDLE;
            w_done_nxt    = 1'b0;
            w_load_ok_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt  <= '0;
            r_word_cnt <= '0;
            r_load_ok  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_gap_cnt <= w_gap_cnt_nxt;
            r_load_ok <= w_load_ok_nxt;
            r_done    <= w_done_nxt;
            if (w_start_acc) begin
                r_word_cnt <= '0;
            end else if (w_hs) begin
                r_word_cnt <= r_word_cnt + 32'd1;
            end
        end
    end

    // write-bus stage: one cycle after the accepting handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_data_p1 <= '0;
            r_wr_addr_p1 <= '0;
            r_wr_en_p1   <= 1'b0;
        end else begin
            r_wr_en_p1 <= w_hs;
            if (w_hs) begin
                r_wr_data_p1 <= s_data;
                r_wr_addr_p1 <= BASE_ADDR + r_word_cnt;
            end
        end
    end

    assign s_ready        = w_s_ready;
    assign weight_wr_data = r_wr_data_p1;
    assign weight_wr_addr = r_wr_addr_p1;
    assign weight_wr_en   = r_wr_en_p1;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign load_ok        = r_load_ok;
    assign word_cnt       = r_word_cnt;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench: instance A (4 words, no gap) runs a cycle table, B (3 words, gap 2)
// and C (226 words) cover gap spacing, abort and asynchronous reset sequences.
module tb_weight_load_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;

    logic        a_start = 1'b0, a_abort = 1'b0;
    logic        b_start = 1'b0, b_abort = 1'b0;
    logic        c_start = 1'b0, c_abort = 1'b0;

    logic        a_rdy, a_en, a_busy, a_done, a_ok;
    logic [15:0] a_wd;
    logic [31:0] a_addr, a_cnt;
    logic        b_rdy, b_en, b_busy, b_done, b_ok;
    logic [15:0] b_wd;
    logic [31:0] b_addr, b_cnt;
    logic        c_rdy, c_en, c_busy, c_done, c_ok;
    logic [15:0] c_wd;
    logic [31:0] c_addr, c_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    weight_load_sequencer #(.BASE_ADDR(32'd23), .NUM_WORDS(4), .WR_GAP(0), .DATA_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(a_rdy),
        .weight_wr_data(a_wd), .weight_wr_addr(a_addr), .weight_wr_en(a_en),
        .busy(a_busy), .done(a_done), .load_ok(a_ok), .word_cnt(a_cnt)
    );

    weight_load_sequencer #(.BASE_ADDR(32'd23), .NUM_WORDS(3), .WR_GAP(2), .DATA_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(b_rdy),
        .weight_wr_data(b_wd), .weight_wr_addr(b_addr), .weight_wr_en(b_en),
        .busy(b_busy), .done(b_done), .load_ok(b_ok), .word_cnt(b_cnt)
    );

    weight_load_sequencer #(.BASE_ADDR(32'd23), .NUM_WORDS(226), .WR_GAP(0), .DATA_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(c_rdy),
        .weight_wr_data(c_wd), .weight_wr_addr(c_addr), .weight_wr_en(c_en),
        .busy(c_busy), .done(c_done), .load_ok(c_ok), .word_cnt(c_cnt)
    );

    typedef struct packed {
        logic        rdy;
        logic        en;
        logic [31:0] addr;
        logic [15:0] wd;
        logic        dn;
        logic        ok;
        logic        bsy;
        logic [31:0] cnt;
    } out_t;

    typedef struct packed {
        logic        st;
        logic        ab;
        logic        vl;
        logic [15:0] d;
        out_t        exp;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    function automatic vec_t mk(int st, int ab, int vl, int d, int rdy, int en, int addr,
                                int wd, int dn, int ok, int bsy, int cnt);
        vec_t v;
        v.st      = 1'(st);
        v.ab      = 1'(ab);
        v.vl      = 1'(vl);
        v.d       = 16'(d);
        v.exp.rdy = 1'(rdy);
        v.exp.en  = 1'(en);
        v.exp.addr = addr;
        v.exp.wd  = 16'(wd);
        v.exp.dn  = 1'(dn);
        v.exp.ok  = 1'(ok);
        v.exp.bsy = 1'(bsy);
        v.exp.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        out_t act;
        int   hs;
        int   rdy_c [3];
        int   wr_c [3];
        int   wr_a [3];
        int   wr_d [3];
        int   n_rdy, n_wr, done_c, done_bsy, done_ok, n_en, n_dn;

        // back-to-back load, bubbles with ignored starts, start+abort in IDLE
        vt[0]  = mk(1,0,0,'h00,  0,0, 0,'h00, 0,0,0,0);
        vt[1]  = mk(0,0,1,'h11,  1,0, 0,'h00, 0,0,1,0);
        vt[2]  = mk(0,0,1,'h12,  1,1,23,'h11, 0,0,1,1);
        vt[3]  = mk(0,0,1,'h13,  1,1,24,'h12, 0,0,1,2);
        vt[4]  = mk(0,0,1,'h14,  1,1,25,'h13, 0,0,1,3);
        vt[5]  = mk(0,0,0,'h00,  0,1,26,'h14, 0,0,1,4);
        vt[6]  = mk(0,0,0,'h00,  0,0,26,'h14, 1,1,0,4);
        vt[7]  = mk(0,0,0,'h00,  0,0,26,'h14, 0,1,0,4);
        vt[8]  = mk(1,0,0,'h00,  0,0,26,'h14, 0,1,0,4);
        vt[9]  = mk(0,0,1,'h21,  1,0,26,'h14, 0,0,1,0);
        vt[10] = mk(0,0,0,'h00,  1,1,23,'h21, 0,0,1,1);
        vt[11] = mk(1,0,0,'h00,  1,0,23,'h21, 0,0,1,1);
        vt[12] = mk(0,0,1,'h22,  1,0,23,'h21, 0,0,1,1);
        vt[13] = mk(0,0,1,'h23,  1,1,24,'h22, 0,0,1,2);
        vt[14] = mk(1,0,0,'h00,  1,1,25,'h23, 0,0,1,3);
        vt[15] = mk(0,0,1,'h24,  1,0,25,'h23, 0,0,1,3);
        vt[16] = mk(0,0,0,'h00,  0,1,26,'h24, 0,0,1,4);
        vt[17] = mk(0,0,0,'h00,  0,0,26,'h24, 1,1,0,4);
        vt[18] = mk(1,1,0,'h00,  0,0,26,'h24, 0,1,0,4);
        vt[19] = mk(0,0,0,'h00,  0,0,26,'h24, 0,0,0,4);
        vt[20] = mk(0,0,0,'h00,  0,0,26,'h24, 0,0,0,4);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("b_reset_busy", 32'(b_busy), 0);
        chk("c_reset_ok", 32'(c_ok), 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_start = vt[i].st;
            a_abort = vt[i].ab;
            s_valid = vt[i].vl;
            s_data  = vt[i].d;
            #1;
            act.rdy = a_rdy;  act.en = a_en;   act.addr = a_addr; act.wd = a_wd;
            act.dn  = a_done; act.ok = a_ok;   act.bsy = a_busy;  act.cnt = a_cnt;
            n_cmp++;
            if (act !== vt[i].exp) begin
                n_fail++;
                $display("FAIL vec%0d: got rdy=%b en=%b addr=%0d data=%h done=%b ok=%b busy=%b cnt=%0d, expected rdy=%b en=%b addr=%0d data=%h done=%b ok=%b busy=%b cnt=%0d",
                         i, act.rdy, act.en, act.addr, act.wd, act.dn, act.ok, act.bsy, act.cnt,
                         vt[i].exp.rdy, vt[i].exp.en, vt[i].exp.addr, vt[i].exp.wd,
                         vt[i].exp.dn, vt[i].exp.ok, vt[i].exp.bsy, vt[i].exp.cnt);
            end
        end
        @(negedge clk);
        a_start = 1'b0; a_abort = 1'b0; s_valid = 1'b0;

        // gap insertion on B: ready every third cycle, writes spaced by three
        b_start = 1'b1;
        hs = 0; n_rdy = 0; n_wr = 0; done_c = -1; done_bsy = -1; done_ok = -1;
        for (int k = 0; k < 3; k++) begin
            rdy_c[k] = -1; wr_c[k] = -1; wr_a[k] = -1; wr_d[k] = -1;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            s_valid = 1'b1;
            s_data  = 16'(49 + hs);
            #1;
            if (b_rdy) begin
                if (n_rdy < 3) rdy_c[n_rdy] = c;
                n_rdy++;
                hs++;
            end
            if (b_en) begin
                if (n_wr < 3) begin
                    wr_c[n_wr] = c;
                    wr_a[n_wr] = int'(b_addr);
                    wr_d[n_wr] = int'(b_wd);
                end
                n_wr++;
            end
            if (b_done) begin
                done_c = c; done_bsy = int'(b_busy); done_ok = int'(b_ok);
            end
        end
        s_valid = 1'b0;
        chk("gap_ready_count", 32'(n_rdy), 3);
        chk("gap_write_count", 32'(n_wr), 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gap_ready_cycle%0d", k), 32'(rdy_c[k]), 32'(3 * k));
            chk($sformatf("gap_write_cycle%0d", k), 32'(wr_c[k]), 32'(3 * k + 1));
            chk($sformatf("gap_write_addr%0d", k), 32'(wr_a[k]), 32'(23 + k));
            chk($sformatf("gap_write_data%0d", k), 32'(wr_d[k]), 32'('h31 + k));
        end
        chk("gap_done_cycle", 32'(done_c), 8);
        chk("gap_busy_at_done", 32'(done_bsy), 0);
        chk("gap_ok_at_done", 32'(done_ok), 1);
        chk("gap_word_cnt", b_cnt, 3);

        // abort on C the cycle after its second handshake
        @(negedge clk);
        c_start = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        c_start = 1'b0; s_valid = 1'b1; s_data = 16'h0041;
        @(negedge clk);
        s_data = 16'h0042;
        @(negedge clk);
        c_abort = 1'b1; s_data = 16'h0043;
        #1;
        chk("abort_cycle_ready", 32'(c_rdy), 0);
        chk("abort_cycle_en", 32'(c_en), 1);
        chk("abort_cycle_addr", c_addr, 24);
        @(negedge clk);
        c_abort = 1'b0;
        #1;
        chk("abort_after_en", 32'(c_en), 0);
        chk("abort_after_busy", 32'(c_busy), 0);
        chk("abort_after_ok", 32'(c_ok), 0);
        chk("abort_after_cnt", c_cnt, 2);
        n_en = 0; n_dn = int'(c_done);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            n_en += int'(c_en);
            n_dn += int'(c_done);
        end
        chk("abort_no_later_writes", 32'(n_en), 0);
        chk("abort_no_done", 32'(n_dn), 0);

        @(negedge clk);
        c_start = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        c_start = 1'b0; s_valid = 1'b1; s_data = 16'h0051;
        #1;
        chk("restart_ready", 32'(c_rdy), 1);
        chk("restart_cnt", c_cnt, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("restart_en", 32'(c_en), 1);
        chk("restart_addr", c_addr, 23);
        chk("restart_data", 32'(c_wd), 32'h51);
        @(negedge clk);
        c_abort = 1'b1;
        @(negedge clk);
        c_abort = 1'b0;

        // asynchronous reset on C after five accepted words
        @(negedge clk);
        c_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            c_start = 1'b0;
            s_valid = 1'b1;
            s_data  = 16'(97 + k);
        end
        @(negedge clk);
        #1;
        chk("pre_reset_cnt", c_cnt, 5);
        chk("pre_reset_addr", c_addr, 27);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_ready", 32'(c_rdy), 0);
        chk("reset_en", 32'(c_en), 0);
        chk("reset_addr", c_addr, 0);
        chk("reset_data", 32'(c_wd), 0);
        chk("reset_busy", 32'(c_busy), 0);
        chk("reset_done", 32'(c_done), 0);
        chk("reset_ok", 32'(c_ok), 0);
        chk("reset_cnt", c_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_en = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_en += int'(c_en) + int'(c_busy);
        end
        chk("post_reset_quiet", 32'(n_en), 0);
        s_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
